layer_output_serializer: RTL and testbench
==========================================

Name: layer_output_serializer

Overview:
- Sits directly downstream of a fully-connected layer block (NN parallel neurons).
- Captures the layer's NN parallel neuron outputs when the layer reports valid, then streams them one element per clock as a (valid, data) stream.
- That stream is the x_valid/x_in pair of the next layer or of the final argmax stage.
- Holds one result buffer; reports overruns rather than stalling, since neurons cannot be back-pressured.

Parameters:
- NN, 10, number of neurons in the upstream layer (element count per result); NN >= 2.
- dataWidth, 16, width of one neuron output / stream element.

Ports:
- CLK  input  1  clock; all logic on the rising edge.
- RESET  input  1  synchronous, active-high reset.
- i_valid  input  NN  per-neuron output-valid from the upstream layer.
- i_data  input  NN*dataWidth  neuron outputs; element k at bits [k*dataWidth +: dataWidth].
- o_valid  output  1  stream element valid.
- o_data  output  dataWidth  stream element.
- o_last  output  1  high with the final element (index NN-1) of a result.
- o_busy  output  1  high while a result is being streamed.
- o_overrun  output  1  sticky: a capture strobe was dropped.
- o_mismatch  output  1  sticky: i_valid was neither all-zero nor all-one.

Behaviour:
- Clock and reset: one clock (CLK); RESET is synchronous and active-high.
- Reset values:
  - o_valid=0, o_last=0, o_busy=0, o_overrun=0, o_mismatch=0, o_data=0.
  - Buffer and index counter cleared; state IDLE.
- Reset dominates every other event in the same cycle. Reset mid-stream aborts the stream; no further elements are emitted.
- Capture strobe: cap = i_valid[0].
- Mismatch: if i_valid != 0 and i_valid != all-ones in any cycle, set o_mismatch (sticky until RESET). The capture decision still follows i_valid[0].
- State IDLE:
  - On cap: latch all of i_data into the buffer, index=0, go to SEND.
  - No output is produced in the capture cycle.
- State SEND (one element per cycle, no gaps):
  - o_valid=1, o_data=buffer[index], o_busy=1, o_last=(index==NN-1).
  - Outputs are registered: a strobe at edge T gives element 0 in cycle T+1 and element NN-1 in cycle T+NN.
  - index increments by 1 per cycle. After index NN-1, return to IDLE with o_valid=0 and o_busy=0, unless a back-to-back capture occurs (next item).
- Back-to-back capture: cap in the same cycle that element NN-1 is output is accepted.
  - Buffer reloads, index=0, stay in SEND.
  - Element 0 of the new result follows with no idle cycle.
- Overrun: cap in SEND while index != NN-1.
  - The strobe and its data are dropped; o_overrun is set (sticky).
  - The current stream continues unchanged.
- Counter: width $clog2(NN). It never exceeds NN-1; no wrap occurs.
- Data: stored and emitted bit-exact. No sign handling, rounding or reordering.

Test Plan:
- Basic capture: NN=10, dataWidth=16, i_data element k = 16'h0100+k, i_valid=10'h3FF for 1 cycle at edge T -> o_valid high T+1..T+10, o_data 0100,0101,…,0109, o_last only at T+10, o_busy matches o_valid, o_valid=0 at T+11.
- Back-to-back: second all-ones strobe (elements 16'hA000+k) exactly at cycle T+10 -> 20 contiguous valid cycles; element 0 = A000 at T+11; o_last at T+10 and T+20; o_overrun stays 0.
- Overrun: second strobe at T+4 with different data -> stream continues 0100..0109 unchanged, o_overrun=1 from T+5 onward, no second stream.
- Mismatch: i_valid=10'h001 for one cycle -> capture occurs (10 elements emitted), o_mismatch=1 sticky; i_valid=10'h3FE -> no capture, o_mismatch=1.
- Reset mid-stream: RESET high at T+5 for 1 cycle -> from T+6 all outputs 0 including sticky flags; a following strobe streams normally from element 0.
- Data integrity: elements 16'hFFFF and 16'h8000 at indices 0 and NN-1, i_data changed every cycle after capture -> emitted values equal the captured snapshot exactly.

Source files
------------

// File: rtl/layer_output_serializer_if.sv
// Bundle between a fully-connected layer, its output serializer and the next stage.
// master = upstream layer / testbench side, slave = serializer side.
interface layer_output_serializer_if #(
  parameter int NN        = 10,
  parameter int dataWidth = 16
);
  logic [NN-1:0]           i_valid;
  logic [NN*dataWidth-1:0] i_data;
  logic                    o_valid;
  logic [dataWidth-1:0]    o_data;
  logic                    o_last;
  logic                    o_busy;
  logic                    o_overrun;
  logic                    o_mismatch;

  modport master (
    output i_valid, i_data,
    input  o_valid, o_data, o_last, o_busy, o_overrun, o_mismatch
  );

  modport slave (
    input  i_valid, i_data,
    output o_valid, o_data, o_last, o_busy, o_overrun, o_mismatch
  );
endinterface

// File: rtl/layer_output_serializer.sv
// Captures NN parallel neuron outputs on a strobe and replays them as a
// one-element-per-clock (valid, data, last) stream. Neurons cannot be
// stalled, so a strobe arriving mid-stream is dropped and flagged instead.
module layer_output_serializer #(
  parameter int NN        = 10,
  parameter int dataWidth = 16
) (
  input  logic                     CLK,
  input  logic                     RESET,
  layer_output_serializer_if.slave bus
);

  localparam int            IW       = (NN > 1) ? $clog2(NN) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NN - 1);

  typedef enum logic {IDLE, SEND} state_t;

  // Unpack the flat neuron bus into one element per neuron.
  logic [dataWidth-1:0] in_elem [NN];
  genvar gi;
  generate
    for (gi = 0; gi < NN; gi++) begin : g_unpack
      assign in_elem[gi] = bus.i_data[gi*dataWidth +: dataWidth];
    end
  endgenerate

  state_t               state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [dataWidth-1:0] buf_q [NN];
  logic [dataWidth-1:0] buf_d [NN];
  logic                 o_valid_q, o_valid_d;
  logic [dataWidth-1:0] o_data_q, o_data_d;
  logic                 o_last_q, o_last_d;
  logic                 overrun_q, overrun_d;
  logic                 mismatch_q, mismatch_d;

  logic          cap;
  logic          bad_valid;
  logic          at_last;
  logic          load;
  logic [IW-1:0] idx_inc;

  // Only neuron 0's valid decides capture; any disagreement among neurons is flagged.
  assign cap       = bus.i_valid[0];
  assign bad_valid = (bus.i_valid != '0) && (bus.i_valid != '1);
  assign at_last   = (idx_q == LAST_IDX);
  // A strobe is taken when idle or exactly while the final element is on the output.
  assign load      = cap && ((state_q == IDLE) || at_last);
  assign idx_inc   = idx_q + 1'b1;

  // Next-state: idx_q always names the element currently on the output, so the
  // next element is fetched from the buffer one cycle ahead into the output flop.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    buf_d      = buf_q;
    o_valid_d  = o_valid_q;
    o_data_d   = o_data_q;
    o_last_d   = o_last_q;
    overrun_d  = overrun_q;
    mismatch_d = mismatch_q | bad_valid;

    if (load) begin
      buf_d     = in_elem;
      idx_d     = '0;
      state_d   = SEND;
      o_valid_d = 1'b1;
      o_data_d  = in_elem[0];
      o_last_d  = 1'b0;  // NN >= 2, so element 0 is never the last
    end else if (state_q == SEND) begin
      if (at_last) begin
        state_d   = IDLE;
        idx_d     = '0;
        o_valid_d = 1'b0;
        o_data_d  = '0;
        o_last_d  = 1'b0;
      end else begin
        if (cap) begin
          overrun_d = 1'b1;
        end
        idx_d    = idx_inc;
        o_data_d = buf_q[idx_inc];
        o_last_d = (idx_inc == LAST_IDX);
      end
    end
  end

  // State and output registers; reset wins over any capture in the same cycle.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      o_valid_q  <= 1'b0;
      o_data_q   <= '0;
      o_last_q   <= 1'b0;
      overrun_q  <= 1'b0;
      mismatch_q <= 1'b0;
      for (int i = 0; i < NN; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      buf_q      <= buf_d;
      o_valid_q  <= o_valid_d;
      o_data_q   <= o_data_d;
      o_last_q   <= o_last_d;
      overrun_q  <= overrun_d;
      mismatch_q <= mismatch_d;
    end
  end

  assign bus.o_valid    = o_valid_q;
  assign bus.o_data     = o_data_q;
  assign bus.o_last     = o_last_q;
  assign bus.o_busy     = (state_q == SEND);
  assign bus.o_overrun  = overrun_q;
  assign bus.o_mismatch = mismatch_q;

endmodule

// File: tb/tb_layer_output_serializer.sv
// Bench for layer_output_serializer: a table of directed cycles, hand-written
// corner sequences, then random traffic, all checked against a queue model.
module tb_layer_output_serializer;

  localparam int NN = 10;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic RESET;

  layer_output_serializer_if #(.NN(NN), .dataWidth(DW)) bus ();

  layer_output_serializer #(.NN(NN), .dataWidth(DW)) dut (
    .CLK   (clk),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: a queue of elements still owed to the output.
  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } elem_t;

  elem_t         mq [$];
  logic          m_v, m_l, m_over, m_mis;
  logic [DW-1:0] m_d;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [NN*DW-1:0] pack_seq(input logic [DW-1:0] base);
    logic [NN*DW-1:0] r;
    for (int k = 0; k < NN; k++) r[k*DW +: DW] = base + DW'(k);
    return r;
  endfunction

  function automatic logic [NN*DW-1:0] rand_data();
    logic [NN*DW-1:0] r;
    for (int k = 0; k < NN; k++) r[k*DW +: DW] = DW'($urandom);
    return r;
  endfunction

  // One clock: drive inputs at negedge, advance model at posedge, compare #1 later.
  task automatic step(input logic rst, input logic [NN-1:0] iv, input logic [NN*DW-1:0] d);
    elem_t e;
    @(negedge clk);
    RESET       = rst;
    bus.i_valid = iv;
    bus.i_data  = d;
    @(posedge clk);
    if (rst) begin
      mq.delete();
      m_over = 1'b0;
      m_mis  = 1'b0;
    end else begin
      if (iv != '0 && iv != '1) m_mis = 1'b1;
      if (iv[0]) begin
        if (mq.size() == 0) begin
          for (int k = 0; k < NN; k++) begin
            e.data = d[k*DW +: DW];
            e.last = (k == NN - 1);
            mq.push_back(e);
          end
        end else begin
          m_over = 1'b1;
        end
      end
    end
    if (!rst && mq.size() > 0) begin
      e   = mq.pop_front();
      m_v = 1'b1;
      m_d = e.data;
      m_l = e.last;
    end else begin
      m_v = 1'b0;
      m_d = '0;
      m_l = 1'b0;
    end
    #1;
    cyc++;
    $display("cyc %0d rst=%b iv=%h | v=%b d=%h last=%b busy=%b ovr=%b mis=%b",
             cyc, rst, iv, bus.o_valid, bus.o_data, bus.o_last, bus.o_busy,
             bus.o_overrun, bus.o_mismatch);
    chk("mdl_valid", 32'(bus.o_valid), 32'(m_v));
    chk("mdl_busy", 32'(bus.o_busy), 32'(m_v));
    chk("mdl_last", 32'(bus.o_last), 32'(m_l));
    if (m_v) chk("mdl_data", 32'(bus.o_data), 32'(m_d));
    chk("mdl_overrun", 32'(bus.o_overrun), 32'(m_over));
    chk("mdl_mismatch", 32'(bus.o_mismatch), 32'(m_mis));
  endtask

  typedef struct {
    logic          rst;
    logic [NN-1:0] iv;
    logic [DW-1:0] base;
    logic          ev;
    logic [DW-1:0] ed;
    logic          el;
    logic          eo;
    logic          em;
  } vec_t;

  vec_t tv [16];

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NN*DW-1:0] d;
    logic [NN-1:0]    iv;
    int               r;

    RESET       = 1'b1;
    bus.i_valid = '0;
    bus.i_data  = '0;
    mq.delete();
    m_over = 1'b0;
    m_mis  = 1'b0;

    // Basic capture: strobe at row 2, elements 0100..0109 on rows 2..11.
    tv[0] = '{1'b1, '0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};
    tv[1] = '{1'b0, '0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};
    tv[2] = '{1'b0, '1, 16'h0100, 1'b1, 16'h0100, 1'b0, 1'b0, 1'b0};
    for (int i = 3; i <= 11; i++)
      tv[i] = '{1'b0, '0, 16'h0000, 1'b1, 16'h0100 + DW'(i - 2), (i == 11), 1'b0, 1'b0};
    tv[12] = '{1'b0, '0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};
    // Partial valid without bit 0: no capture, mismatch flag set and sticky.
    tv[13] = '{1'b0, 10'h3FE, 16'h7700, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1};
    tv[14] = '{1'b0, '0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1};
    tv[15] = '{1'b1, '0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < 16; i++) begin
      step(tv[i].rst, tv[i].iv, pack_seq(tv[i].base));
      chk("tbl_valid", 32'(bus.o_valid), 32'(tv[i].ev));
      chk("tbl_busy", 32'(bus.o_busy), 32'(tv[i].ev));
      chk("tbl_last", 32'(bus.o_last), 32'(tv[i].el));
      if (tv[i].ev || tv[i].rst) chk("tbl_data", 32'(bus.o_data), 32'(tv[i].ed));
      chk("tbl_overrun", 32'(bus.o_overrun), 32'(tv[i].eo));
      chk("tbl_mismatch", 32'(bus.o_mismatch), 32'(tv[i].em));
    end

    // Back-to-back: second strobe while element 9 is shown -> A000 next cycle.
    step(1'b0, '1, pack_seq(16'h0100));
    for (int i = 1; i < NN; i++) step(1'b0, '0, '0);
    chk("b2b_last_first", 32'(bus.o_last), 32'd1);
    step(1'b0, '1, pack_seq(16'hA000));
    chk("b2b_valid", 32'(bus.o_valid), 32'd1);
    chk("b2b_elem0", 32'(bus.o_data), 32'h0000_A000);
    for (int i = 1; i < NN; i++) step(1'b0, '0, '0);
    chk("b2b_last_second", 32'(bus.o_last), 32'd1);
    chk("b2b_data9", 32'(bus.o_data), 32'h0000_A009);
    step(1'b0, '0, '0);
    chk("b2b_end_valid", 32'(bus.o_valid), 32'd0);
    chk("b2b_no_overrun", 32'(bus.o_overrun), 32'd0);

    // Overrun: strobe while element 3 is shown is dropped.
    step(1'b0, '1, pack_seq(16'h0100));
    for (int i = 1; i < 4; i++) step(1'b0, '0, '0);
    step(1'b0, '1, pack_seq(16'h5500));
    chk("ovr_flag", 32'(bus.o_overrun), 32'd1);
    chk("ovr_data4", 32'(bus.o_data), 32'h0000_0104);
    for (int i = 5; i < NN; i++) step(1'b0, '0, '0);
    chk("ovr_data9", 32'(bus.o_data), 32'h0000_0109);
    step(1'b0, '0, '0);
    chk("ovr_no_second", 32'(bus.o_valid), 32'd0);
    chk("ovr_sticky", 32'(bus.o_overrun), 32'd1);

    // Mismatch: only bit 0 valid still captures.
    step(1'b1, '0, '0);
    step(1'b0, 10'h001, pack_seq(16'h0200));
    chk("mis_capture", 32'(bus.o_valid), 32'd1);
    chk("mis_data0", 32'(bus.o_data), 32'h0000_0200);
    chk("mis_flag", 32'(bus.o_mismatch), 32'd1);
    for (int i = 1; i < NN; i++) step(1'b0, '0, '0);
    step(1'b0, 10'h3FE, pack_seq(16'h0300));
    chk("mis_no_capture", 32'(bus.o_valid), 32'd0);
    chk("mis_sticky", 32'(bus.o_mismatch), 32'd1);

    // Reset mid-stream clears everything; next strobe restarts at element 0.
    step(1'b0, '1, pack_seq(16'h0100));
    for (int i = 1; i < 5; i++) step(1'b0, '0, '0);
    step(1'b1, '0, '0);
    chk("rst_valid", 32'(bus.o_valid), 32'd0);
    chk("rst_data", 32'(bus.o_data), 32'd0);
    chk("rst_mismatch", 32'(bus.o_mismatch), 32'd0);
    step(1'b0, '1, pack_seq(16'h0300));
    chk("rst_restart", 32'(bus.o_data), 32'h0000_0300);
    for (int i = 1; i < NN; i++) step(1'b0, '0, rand_data());

    // Data integrity: extreme values at the ends, inputs churning afterwards.
    d = rand_data();
    d[0 +: DW]        = 16'hFFFF;
    d[(NN-1)*DW +: DW] = 16'h8000;
    step(1'b0, '1, d);
    chk("int_first", 32'(bus.o_data), 32'h0000_FFFF);
    for (int i = 1; i < NN; i++) step(1'b0, '0, rand_data());
    chk("int_last", 32'(bus.o_data), 32'h0000_8000);
    chk("int_last_flag", 32'(bus.o_last), 32'd1);

    // Random traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      r = int'($urandom_range(0, 199));
      if (r < 20)       iv = '1;
      else if (r < 26)  iv = NN'($urandom);
      else              iv = '0;
      step(r == 199, iv, rand_data());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
